// File: rtl/spi_master_pkg.sv
// Shared definitions for the SPI master: FSM state encoding, the default sck
// divider and the frame-length / data widths.
package spi_master_pkg;

    localparam int unsigned DivDefault = 4;   // clk cycles per sck half-period
    localparam int unsigned LenW       = 4;   // width of req_len (N - 1)
    localparam int unsigned DataW      = 16;  // maximum frame length in bits
    localparam int unsigned CntW       = 8;   // divider counter width (DIV <= 255)

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StXfer,
        StHold,
        StDone
    } state_e;

endpackage

// File: rtl/spi_clkgen.sv
// SPI clock generator: a DIV-cycle counter producing a tick strobe every DIV
// enabled cycles, plus the mode-0 sck waveform and its rise/fall strobes.
//   clk, reset  : system clock, asynchronous active-high reset
//   en_i        : run the divider counter (held at 0 otherwise)
//   sck_en_i    : let sck toggle on each tick (sck forced low otherwise)
//   tick_o      : last cycle of a DIV-cycle period
//   rise_o      : sck goes high at the coming clk edge
//   fall_o      : sck goes low at the coming clk edge
//   sck_o       : registered SPI clock
module spi_clkgen
    import spi_master_pkg::*;
#(
    parameter int unsigned DIV = DivDefault
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic sck_en_i,
    output logic tick_o,
    output logic rise_o,
    output logic fall_o,
    output logic sck_o
);

    localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            sck_q, sck_d;

    always_comb begin
        tick_o = en_i && (cnt_q == CntMax);
        rise_o = tick_o && sck_en_i && !sck_q;
        fall_o = tick_o && sck_en_i && sck_q;
        cnt_d  = cnt_q;
        sck_d  = sck_q;
        if (!en_i || tick_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
        if (!sck_en_i) begin
            sck_d = 1'b0;
        end else if (tick_o) begin
            sck_d = ~sck_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sck_q <= sck_d;
        end
    end

    assign sck_o = sck_q;

endmodule

// File: rtl/spi_master.sv
// SPI master, mode 0, MSB first, 1..16-bit frames.
//   clk, reset           : system clock, asynchronous active-high reset
//   req_valid/req_ready  : request handshake; req_data/req_len latched on accept
//   rsp_valid            : one-cycle pulse when rsp_data is updated
//   rsp_data             : received bits, right-aligned, held until next frame ends
//   sck, ss, mosi, miso  : SPI bus (ss active-low, sck idle low)
module spi_master
    import spi_master_pkg::*;
#(
    parameter int unsigned DIV = DivDefault
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [DataW-1:0] req_data,
    input  logic [LenW-1:0]  req_len,
    output logic             rsp_valid,
    output logic [DataW-1:0] rsp_data,
    output logic             sck,
    output logic             ss,
    output logic             mosi,
    input  logic             miso
);

    state_e           state_q, state_d;
    logic [DataW-1:0] tx_q, tx_d;
    logic [DataW-1:0] rx_q, rx_d;
    logic [DataW-1:0] rsp_q, rsp_d;
    logic [LenW-1:0]  len_q, len_d;
    logic [LenW-1:0]  bit_q, bit_d;
    logic [LenW-1:0]  tx_idx;
    logic             tick, rise, fall;
    logic             cg_en, sck_en;

    spi_clkgen #(
        .DIV(DIV)
    ) u_clkgen (
        .clk      (clk),
        .reset    (reset),
        .en_i     (cg_en),
        .sck_en_i (sck_en),
        .tick_o   (tick),
        .rise_o   (rise),
        .fall_o   (fall),
        .sck_o    (sck)
    );

    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        rsp_d     = rsp_q;
        len_d     = len_q;
        bit_d     = bit_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        ss        = 1'b1;
        mosi      = 1'b0;
        cg_en     = 1'b0;
        sck_en    = 1'b0;
        // bit_q counts completed bits, so the current tx bit is N-1-bit_q.
        tx_idx    = len_q - bit_q;

        unique case (state_q)
            StIdle: begin
                // Held low while reset is asserted even though state is already idle.
                req_ready = !reset;
                if (req_valid && !reset) begin
                    tx_d    = req_data;
                    len_d   = req_len;
                    rx_d    = '0;
                    bit_d   = '0;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                ss    = 1'b0;
                mosi  = tx_q[tx_idx];
                cg_en = 1'b1;
                if (tick) begin
                    state_d = StXfer;
                end
            end
            StXfer: begin
                ss     = 1'b0;
                mosi   = tx_q[tx_idx];
                cg_en  = 1'b1;
                sck_en = 1'b1;
                if (rise) begin
                    rx_d = {rx_q[DataW-2:0], miso};
                end
                if (fall) begin
                    if (bit_q == len_q) begin
                        state_d = StHold;
                    end else begin
                        bit_d = bit_q + LenW'(1);
                    end
                end
            end
            StHold: begin
                ss    = 1'b0;
                mosi  = tx_q[tx_idx];
                cg_en = 1'b1;
                if (tick) begin
                    rsp_d   = rx_q;
                    state_d = StDone;
                end
            end
            StDone: begin
                rsp_valid = 1'b1;
                state_d   = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            tx_q    <= '0;
            rx_q    <= '0;
            rsp_q   <= '0;
            len_q   <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rsp_q   <= rsp_d;
            len_q   <= len_d;
            bit_q   <= bit_d;
        end
    end

    assign rsp_data = rsp_q;

endmodule

// File: tb/tb_spi_master.sv
module tb_spi_master;

    logic        clk;
    logic        reset;
    logic [2:0]  req_valid, req_ready, rsp_valid, sck, ss, mosi, miso, miso_r, lb;
    logic [15:0] req_data [3];
    logic [3:0]  req_len  [3];
    logic [15:0] rsp_data [3];
    logic [1:0]  mode     [3];   // slave model: 0 loopback, 1 tied high, 2 bitrev, 3 random

    int divs [3] = '{1, 2, 4};
    int total = 0;
    int bad   = 0;

    // Slave / bus monitor state
    logic        prev_ss [3];
    logic        prev_sck[3];
    logic [15:0] rx_seen [3];
    logic [15:0] tx_seen [3];
    logic [15:0] cap     [3];
    int          rises   [3];
    int          falls   [3];
    int          low_cnt [3];
    int          last_low[3];
    int          gap_cnt [3];
    int          last_gap[3];
    int          rsp_cnt [3];

    spi_master #(.DIV(1)) u_dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_data(req_data[0]), .req_len(req_len[0]), .rsp_valid(rsp_valid[0]),
        .rsp_data(rsp_data[0]), .sck(sck[0]), .ss(ss[0]), .mosi(mosi[0]), .miso(miso[0])
    );
    spi_master #(.DIV(2)) u_dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_data(req_data[1]), .req_len(req_len[1]), .rsp_valid(rsp_valid[1]),
        .rsp_data(rsp_data[1]), .sck(sck[1]), .ss(ss[1]), .mosi(mosi[1]), .miso(miso[1])
    );
    spi_master #(.DIV(4)) u_dut2 (
        .clk(clk), .reset(reset), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_data(req_data[2]), .req_len(req_len[2]), .rsp_valid(rsp_valid[2]),
        .rsp_data(rsp_data[2]), .sck(sck[2]), .ss(ss[2]), .mosi(mosi[2]), .miso(miso[2])
    );

    assign lb   = {mode[2] == 2'd0, mode[1] == 2'd0, mode[0] == 2'd0};
    assign miso = (lb & mosi) | (~lb & miso_r);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mask_of(input int n);
        return (32'd1 << n) - 32'd1;
    endfunction

    function automatic logic [7:0] bitrev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    // Next miso bit the slave presents for frame bit i (mode 0 uses mosi directly).
    function automatic logic slave_bit(input int k, input int i);
        case (mode[k])
            2'd1:    return 1'b1;
            2'd2:    return (i >= 8 && i < 16) ? cap[k][15-i] : 1'b0;
            2'd3:    return 1'($urandom);
            default: return 1'b0;
        endcase
    endfunction

    // Mode-0 slave: sample on sck rise, change miso after sck fall. Sampled at negedge.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rsp_valid[k]) rsp_cnt[k]++;
            if (ss[k]) begin
                if (!prev_ss[k]) begin
                    last_low[k] = low_cnt[k];
                    gap_cnt[k]  = 0;
                end
                gap_cnt[k]++;
            end else begin
                if (prev_ss[k]) begin
                    last_gap[k] = gap_cnt[k];
                    low_cnt[k]  = 0;
                    rises[k]    = 0;
                    falls[k]    = 0;
                    rx_seen[k]  = '0;
                    tx_seen[k]  = '0;
                    cap[k]      = '0;
                    miso_r[k]   = slave_bit(k, 0);
                end
                low_cnt[k]++;
                if (sck[k] && !prev_sck[k]) begin
                    rx_seen[k]        = {rx_seen[k][14:0], miso[k]};
                    tx_seen[k]        = {tx_seen[k][14:0], mosi[k]};
                    cap[k][rises[k]] = mosi[k];
                    rises[k]++;
                end
                if (!sck[k] && prev_sck[k]) begin
                    falls[k]++;
                    miso_r[k] = slave_bit(k, falls[k]);
                end
            end
            prev_ss[k]  = ss[k];
            prev_sck[k] = sck[k];
        end
    end

    // Called at #1 after the accepting edge.
    task automatic finish_frame(input int k, input logic [15:0] d, input logic [3:0] l,
                                input logic [1:0] m, input bit keep,
                                input logic [15:0] nxt, input logic [3:0] nlen);
        int          n       = int'(l) + 1;
        int          lat_exp = (2 * n + 2) * divs[k];
        int          edges   = 0;
        int          rdy_hi  = 0;
        logic [31:0] exp;
        if (!keep) req_valid[k] = 1'b0;
        req_data[k] = nxt;
        req_len[k]  = nlen;
        do begin
            @(posedge clk);
            #1;
            edges++;
            if (req_ready[k]) rdy_hi++;
            if (!keep && edges == 7) begin
                req_data[k] = 16'($urandom);
                req_len[k]  = 4'($urandom);
            end
        end while (!rsp_valid[k] && edges < 5000);
        case (m)
            2'd0:    exp = 32'(d) & mask_of(n);
            2'd1:    exp = mask_of(n);
            2'd2:    exp = {24'd0, bitrev8(d[15:8])};
            default: exp = {16'd0, rx_seen[k]};
        endcase
        check("latency", 32'(edges), 32'(lat_exp));
        check("rsp_data", {16'd0, rsp_data[k]}, exp);
        check("ready_busy", 32'(rdy_hi), 32'd0);
        @(posedge clk);
        #1;
        check("rsp_pulse", 32'(rsp_valid[k]), 32'd0);
        check("rsp_hold", {16'd0, rsp_data[k]}, exp);
        check("ss_low", 32'(last_low[k]), 32'(lat_exp));
        check("mosi_bits", {16'd0, tx_seen[k]}, 32'(d) & mask_of(n));
        check("sck_rises", 32'(rises[k]), 32'(n));
        check("idle_ready", 32'(req_ready[k]), 32'd1);
    endtask

    task automatic do_frame(input int k, input logic [15:0] d, input logic [3:0] l,
                            input logic [1:0] m, input bit keep,
                            input logic [15:0] nxt, input logic [3:0] nlen);
        int n = 0;
        mode[k]      = m;
        req_valid[k] = 1'b1;
        req_data[k]  = d;
        req_len[k]   = l;
        while (!req_ready[k] && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("ready_wait", 32'(req_ready[k]), 32'd1);
        @(posedge clk);
        #1;
        finish_frame(k, d, l, m, keep, nxt, nlen);
    endtask

    initial begin
        int          c0;
        int          n;
        logic [15:0] d;
        logic [3:0]  l;
        logic [1:0]  m;

        reset     = 1'b1;
        req_valid = '0;
        miso_r    = '0;
        for (int k = 0; k < 3; k++) begin
            req_data[k] = '0;
            req_len[k]  = '0;
            mode[k]     = 2'd0;
            prev_ss[k]  = 1'b1;
            prev_sck[k] = 1'b0;
            rx_seen[k]  = '0;
            tx_seen[k]  = '0;
            cap[k]      = '0;
            rises[k]    = 0;
            falls[k]    = 0;
            low_cnt[k]  = 0;
            last_low[k] = 0;
            gap_cnt[k]  = 100;
            last_gap[k] = 100;
            rsp_cnt[k]  = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check("rst_ready", 32'(req_ready[k]), 32'd0);
            check("rst_ss", 32'(ss[k]), 32'd1);
            check("rst_sck", 32'(sck[k]), 32'd0);
            check("rst_mosi", 32'(mosi[k]), 32'd0);
            check("rst_rsp_valid", 32'(rsp_valid[k]), 32'd0);
            check("rst_rsp_data", {16'd0, rsp_data[k]}, 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) check("ready_after_rst", 32'(req_ready[k]), 32'd1);

        // Directed frames
        do_frame(2, 16'h00A5, 4'd7, 2'd0, 1'b0, 16'h5A5A, 4'd3);    // loopback, 72 edges
        do_frame(1, 16'h1300, 4'd15, 2'd2, 1'b0, 16'h0000, 4'd0);   // bitrev slave
        do_frame(0, 16'h0000, 4'd0, 2'd1, 1'b0, 16'hFFFF, 4'd15);   // N=1, miso high
        for (int k = 0; k < 3; k++) do_frame(k, 16'hFFFF, 4'd15, 2'd0, 1'b0, 16'h1234, 4'd2);

        // Reset during the 5th sck high phase on the DIV=4 instance
        mode[2]      = 2'd0;
        req_valid[2] = 1'b1;
        req_data[2]  = 16'h00C3;
        req_len[2]   = 4'd7;
        @(posedge clk);
        #1;
        req_valid[2] = 1'b0;
        n = 0;
        while (rises[2] != 5 && n < 1000) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("abort_sck_high", 32'(sck[2]), 32'd1);
        c0    = rsp_cnt[2];
        reset = 1'b1;
        #1;
        check("abort_ss", 32'(ss[2]), 32'd1);
        check("abort_sck", 32'(sck[2]), 32'd0);
        check("abort_mosi", 32'(mosi[2]), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("abort_ready", 32'(req_ready[2]), 32'd0);
        check("abort_rsp_data", {16'd0, rsp_data[2]}, 32'd0);
        req_valid[2] = 1'b1;
        req_data[2]  = 16'h0B7E;
        req_len[2]   = 4'd11;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("accept_after_rst", 32'(ss[2]), 32'd0);
        check("abort_no_rsp", 32'(rsp_cnt[2]), 32'(c0));
        finish_frame(2, 16'h0B7E, 4'd11, 2'd0, 1'b0, 16'h0, 4'd0);

        // Back-to-back with req_valid held high
        do_frame(1, 16'hBEEF, 4'd9, 2'd0, 1'b1, 16'h7123, 4'd4);
        do_frame(1, 16'h7123, 4'd4, 2'd3, 1'b1, 16'h9ABC, 4'd15);
        check("b2b_gap1", 32'(last_gap[1] >= 2), 32'd1);
        do_frame(1, 16'h9ABC, 4'd15, 2'd0, 1'b0, 16'h0, 4'd0);
        check("b2b_gap2", 32'(last_gap[1] >= 2), 32'd1);

        // Randomized frames on every divider
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 6; i++) begin
                d = 16'($urandom);
                l = 4'($urandom);
                m = 2'($urandom_range(0, 3));
                if (m == 2'd2) l = 4'd15;
                do_frame(k, d, l, m, 1'b0, 16'($urandom), 4'($urandom));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter DIV, default 4, meaning clk cycles per sck half-period (legal range 1..255).
REQ-002 SHALL have port clk  in  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port req_valid  in  1  transfer request.
REQ-005 SHALL have port req_ready  out  1  request accepted when req_valid&req_ready at a clk edge.
REQ-006 SHALL have port req_data  in  16  transmit bits, sent MSB-first starting at bit N-1.
REQ-007 SHALL have port req_len  in  4  frame length minus one; N = req_len+1 (1..16).
REQ-008 SHALL have port rsp_valid  out  1  one-cycle pulse, rsp_data valid.
REQ-009 SHALL have port rsp_data  out  16  received bits, right-aligned, first received bit at bit N-1, upper bits zero.
REQ-010 SHALL have port sck  out  1  SPI clock, mode 0 (idle low).
REQ-011 SHALL have port ss  out  1  slave select, active-low.
REQ-012 SHALL have port mosi  out  1  serial data to the slave.
REQ-013 SHALL have port miso  in  1  serial data from the slave.

Function
REQ-014 SHALL implement the states IDLE, SETUP, XFER, HOLD, DONE.
REQ-015 IDLE: req_ready=1, ss=1, sck=0, mosi=0; on accept latch req_data and N, then go to SETUP.
REQ-016 SETUP: ss=0, mosi=tx[N-1], sck=0; lasts exactly DIV cycles, then go to XFER.
REQ-017 XFER: sck toggles every DIV cycles, starting low, for exactly 2N half-periods (N rising, N falling edges).
REQ-018 Each sck rising edge SHALL shift miso (value in the cycle before the rise) into rx LSB.
REQ-019 Each sck falling edge except the last SHALL advance mosi to the next lower tx bit; mosi is stable across every rising edge.
REQ-020 After the N-th falling edge, go to HOLD: ss=0, sck=0 for DIV cycles.
REQ-021 DONE: ss=1, rsp_valid=1 for exactly one cycle, rsp_data=rx; next state IDLE.
REQ-022 rsp_valid SHALL rise exactly (2N+2)*DIV clk edges after the accepting edge.
REQ-023 rsp_data SHALL hold its value until the next DONE.
REQ-024 req_ready SHALL be 0 in every state except IDLE; requests are never queued.
REQ-025 rsp has no backpressure; a missed pulse is lost.
REQ-026 The DIV counter SHALL wrap from DIV-1 to 0; DIV=1 yields sck = clk/2.
REQ-027 The bit counter SHALL count 0..N-1 without wrap; N=16 (req_len=15) is legal; N=1 is legal.
REQ-028 Input changes on req_data/req_len after acceptance SHALL have no effect on the current frame.

Reset
REQ-029 While reset=1 (asynchronously): state=IDLE, ss=1, sck=0, mosi=0, req_ready=0, rsp_valid=0, rsp_data=0, counters=0.
REQ-030 Reset mid-frame SHALL abort immediately with no rsp_valid; req_ready=1 from the first edge after deassertion.

Structure
REQ-031 Package spi_master_pkg SHALL hold the state enum, the DIV default and the length width constant.
REQ-032 SHALL instantiate sub-module spi_clkgen (DIV counter, rise/fall tick strobes, gated by an enable); the FSM and shift registers stay in spi_master.

Verification
REQ-033 Loopback (miso=mosi), DIV=4, req_len=7, req_data=0x00A5 -> rsp_data=0x00A5; rsp_valid 72 edges after accept; 8 sck rises.
REQ-034 bitrev slave, DIV=2, req_len=15, req_data=0x1300 -> rsp_data[7:0]=0xC8; ss low for the whole frame.
REQ-035 miso tied 1, req_len=0 (N=1), DIV=1 -> rsp_data=0x0001, rsp_valid 4 edges after accept.
REQ-036 Reset asserted during the 5th sck high phase -> ss=1, sck=0 the same cycle, no rsp_valid; a new request is accepted 1 edge after release.
REQ-037 req_valid held high continuously -> back-to-back frames, req_ready high only in IDLE, ss high for at least 2 cycles (DONE+IDLE) between frames.
REQ-038 Loopback, req_len=15, req_data=0xFFFF -> 0xFFFF; change req_data mid-frame -> no effect.
